// File: rtl/ide_host_pio.sv
// IDE/ATA host-side PIO cycle engine: sequences one register/data cycle at a
// time with programmable setup, strobe, hold and recovery timing, IORDY
// stretching with timeout, and synchronizes the device interrupt.
module ide_host_pio #(
  parameter int unsigned T_SETUP   = 3,
  parameter int unsigned T_PULSE   = 8,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_RECOVER = 4,
  parameter int unsigned IORDY_TO  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_cs3,
  input  logic [2:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic [2:0]  da,
  output logic        cs1fx_,
  output logic        cs3fx_,
  output logic        dior_,
  output logic        diow_,
  output logic [15:0] dd_out,
  output logic        dd_oe,
  input  logic [15:0] dd_in,
  input  logic        iordy,
  input  logic        intrq,
  output logic        irq,
  output logic        irq_rise
);

  // Zero-valued timing parameters behave as one clock.
  localparam int unsigned TS = (T_SETUP   == 0) ? 1 : T_SETUP;
  localparam int unsigned TP = (T_PULSE   == 0) ? 1 : T_PULSE;
  localparam int unsigned TH = (T_HOLD    == 0) ? 1 : T_HOLD;
  localparam int unsigned TR = (T_RECOVER == 0) ? 1 : T_RECOVER;
  localparam int unsigned TO = (IORDY_TO  == 0) ? 1 : IORDY_TO;

  localparam int unsigned M1   = (TS > TP) ? TS : TP;
  localparam int unsigned M2   = (M1 > TH) ? M1 : TH;
  localparam int unsigned M3   = (M2 > TR) ? M2 : TR;
  localparam int unsigned MAXP = (M3 > TO) ? M3 : TO;
  localparam int unsigned CW   = $clog2(MAXP + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_WAITRDY = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  logic [2:0]    state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic          wr, nxt_wr;
  logic [2:0]    nxt_da;
  logic          nxt_cs1, nxt_cs3, nxt_dior, nxt_diow, nxt_dd_oe;
  logic [15:0]   nxt_dd_out, nxt_rdata;
  logic          nxt_rsp_valid, nxt_timeout;
  logic          iordy_m, iordy_s, intrq_m;

  assign req_ready = (state == S_IDLE);

  // Two-flop synchronizers for the asynchronous device handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iordy_m  <= 1'b0;
      iordy_s  <= 1'b0;
      intrq_m  <= 1'b0;
      irq      <= 1'b0;
      irq_rise <= 1'b0;
    end else begin
      iordy_m  <= iordy;
      iordy_s  <= iordy_m;
      intrq_m  <= intrq;
      irq      <= intrq_m;
      irq_rise <= intrq_m & ~irq;
    end
  end

  // Next-state and next-output decode for the PIO cycle sequencer.
  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_wr        = wr;
    nxt_da        = da;
    nxt_cs1       = cs1fx_;
    nxt_cs3       = cs3fx_;
    nxt_dior      = dior_;
    nxt_diow      = diow_;
    nxt_dd_out    = dd_out;
    nxt_dd_oe     = dd_oe;
    nxt_rdata     = rsp_rdata;
    nxt_timeout   = rsp_timeout;
    nxt_rsp_valid = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          nxt_wr      = req_write;
          nxt_da      = req_addr;
          nxt_cs1     = req_cs3;
          nxt_cs3     = ~req_cs3;
          nxt_dd_oe   = req_write;
          nxt_timeout = 1'b0;
          if (req_write) nxt_dd_out = req_wdata;
          nxt_cnt     = '0;
          nxt_state   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt == CW'(TS - 1)) begin
          nxt_dior  = wr;
          nxt_diow  = ~wr;
          nxt_cnt   = '0;
          nxt_state = S_STROBE;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end

      S_STROBE: begin
        if (cnt == CW'(TP - 1)) begin
          nxt_cnt = '0;
          if (iordy_s) begin
            nxt_dior  = 1'b1;
            nxt_diow  = 1'b1;
            if (!wr) nxt_rdata = dd_in;
            nxt_state = S_HOLD;
          end else begin
            nxt_state = S_WAITRDY;
          end
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end

      S_WAITRDY: begin
        if (iordy_s) begin
          nxt_dior  = 1'b1;
          nxt_diow  = 1'b1;
          if (!wr) nxt_rdata = dd_in;
          nxt_cnt   = '0;
          nxt_state = S_HOLD;
        end else if (cnt == CW'(TO - 1)) begin
          nxt_dior    = 1'b1;
          nxt_diow    = 1'b1;
          nxt_timeout = 1'b1;
          if (!wr) nxt_rdata = 16'hFFFF;
          nxt_cnt     = '0;
          nxt_state   = S_HOLD;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end

      S_HOLD: begin
        if (cnt == CW'(TH - 1)) begin
          nxt_cs1       = 1'b1;
          nxt_cs3       = 1'b1;
          nxt_dd_oe     = 1'b0;
          nxt_rsp_valid = 1'b1;
          nxt_cnt       = '0;
          nxt_state     = S_RECOVER;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end

      S_RECOVER: begin
        if (cnt == CW'(TR - 1)) begin
          nxt_cnt   = '0;
          nxt_state = S_IDLE;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end

      default: begin
        nxt_cnt   = '0;
        nxt_state = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered bus/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wr          <= 1'b0;
      da          <= 3'd0;
      cs1fx_      <= 1'b1;
      cs3fx_      <= 1'b1;
      dior_       <= 1'b1;
      diow_       <= 1'b1;
      dd_out      <= 16'd0;
      dd_oe       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'd0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      wr          <= nxt_wr;
      da          <= nxt_da;
      cs1fx_      <= nxt_cs1;
      cs3fx_      <= nxt_cs3;
      dior_       <= nxt_dior;
      diow_       <= nxt_diow;
      dd_out      <= nxt_dd_out;
      dd_oe       <= nxt_dd_oe;
      rsp_valid   <= nxt_rsp_valid;
      rsp_rdata   <= nxt_rdata;
      rsp_timeout <= nxt_timeout;
    end
  end

endmodule

// File: tb/tb_ide_host_pio.sv
// Bench for ide_host_pio: directed and randomized PIO cycles checked against
// a timeline model built from the cycle timing rules.
module tb_ide_host_pio;

  localparam int T_SETUP   = 3;
  localparam int T_PULSE   = 8;
  localparam int T_HOLD    = 2;
  localparam int T_RECOVER = 4;
  localparam int IORDY_TO  = 1024;
  localparam int LIMIT     = 1200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_cs3 = 1'b0;
  logic [2:0]  req_addr = 3'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic [2:0]  da;
  logic        cs1fx_, cs3fx_, dior_, diow_;
  logic [15:0] dd_out;
  logic        dd_oe;
  logic [15:0] dd_in = 16'd0;
  logic        iordy = 1'b1;
  logic        intrq = 1'b0;
  logic        irq, irq_rise;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Observations of the most recent transaction, relative to its accept edge.
  int          o_fall, o_rise, o_rv, o_rvcnt, o_ready, o_bad;
  int          o_acc_cyc, o_rv_cyc;
  bit          o_acc_to;
  logic [15:0] o_rdata;
  logic        o_to;

  ide_host_pio #(
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
    .T_RECOVER(T_RECOVER), .IORDY_TO(IORDY_TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_cs3(req_cs3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .da(da), .cs1fx_(cs1fx_), .cs3fx_(cs3fx_), .dior_(dior_), .diow_(diow_),
    .dd_out(dd_out), .dd_oe(dd_oe), .dd_in(dd_in), .iordy(iordy),
    .intrq(intrq), .irq(irq), .irq_rise(irq_rise)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference timeline: edge (relative to accept) where the strobe is released.
  // low = 0: iordy always high; low > 0: iordy rises 'low' clocks after the
  // strobe asserts; low < 0: iordy never rises. Synchronizer adds 2 clocks,
  // and the sequencer acts on the following edge.
  function automatic int exp_rise(input int low);
    int rdy;
    if (low == 0) return T_SETUP + T_PULSE;
    if (low < 0) return T_SETUP + T_PULSE + IORDY_TO;
    rdy = T_SETUP + low + 3;
    if (rdy <= T_SETUP + T_PULSE) return T_SETUP + T_PULSE;
    if (rdy <= T_SETUP + T_PULSE + IORDY_TO) return rdy;
    return T_SETUP + T_PULSE + IORDY_TO;
  endfunction

  function automatic bit exp_to(input int low);
    if (low < 0) return 1'b1;
    if (low == 0) return 1'b0;
    return (T_SETUP + low + 3) > (T_SETUP + T_PULSE + IORDY_TO);
  endfunction

  // Drive one request and record what the bus and response did; no checks here.
  task automatic do_txn(input logic w, input logic c3, input logic [2:0] a,
                        input logic [15:0] wd, input logic [15:0] dev,
                        input int low, input bit hold);
    int   wn;
    bit   done;
    logic strobe, other;
    o_fall = -1; o_rise = -1; o_rv = -1; o_rvcnt = 0; o_ready = -1; o_bad = 0;
    o_acc_to = 1'b0; o_rdata = 16'd0; o_to = 1'b0; o_rv_cyc = 0;
    req_write = w; req_cs3 = c3; req_addr = a; req_wdata = wd; dd_in = dev;
    if (low != 0) iordy = 1'b0;
    req_valid = 1'b1;
    wn = 0;
    while (req_ready !== 1'b1 && wn < 64) begin
      @(posedge clk); #1; wn++;
    end
    if (req_ready !== 1'b1) begin
      o_acc_to = 1'b1; req_valid = 1'b0; iordy = 1'b1;
      return;
    end
    @(posedge clk); #1;
    o_acc_cyc = cyc;
    if (!hold) req_valid = 1'b0;
    done = 1'b0;
    for (int n = 0; n < LIMIT && !done; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      strobe = w ? diow_ : dior_;
      other  = w ? dior_ : diow_;
      if (o_fall < 0 && strobe === 1'b0) o_fall = n;
      else if (o_fall >= 0 && o_rise < 0 && strobe === 1'b1) o_rise = n;
      if (other !== 1'b1) o_bad++;
      if (rsp_valid === 1'b1) begin
        o_rvcnt++;
        if (o_rv < 0) begin
          o_rv = n; o_rv_cyc = cyc; o_rdata = rsp_rdata; o_to = rsp_timeout;
        end
      end
      if (o_rv < 0) begin
        if (da !== a || cs1fx_ !== c3 || cs3fx_ !== ~c3 || dd_oe !== w ||
            (w && dd_out !== wd)) o_bad++;
      end else begin
        if (cs1fx_ !== 1'b1 || cs3fx_ !== 1'b1 || dd_oe !== 1'b0) o_bad++;
        if (o_ready < 0 && req_ready === 1'b1) begin
          o_ready = n; done = 1'b1;
        end
      end
      if (low > 0 && n == T_SETUP + low) iordy = 1'b1;
    end
    iordy = 1'b1;
  endtask

  task automatic test_reset;
    intrq = 1'b1;
    #1 rst = 1'b1;
    #2;
    checks++; if (dior_ !== 1'b1 || diow_ !== 1'b1) $display("FAIL reset_strobes: dior_=%b diow_=%b expected 1 1", dior_, diow_); else passes++;
    checks++; if (cs1fx_ !== 1'b1 || cs3fx_ !== 1'b1) $display("FAIL reset_cs: cs1fx_=%b cs3fx_=%b expected 1 1", cs1fx_, cs3fx_); else passes++;
    checks++; if (da !== 3'd0 || dd_out !== 16'd0 || dd_oe !== 1'b0) $display("FAIL reset_bus: da=%0d dd_out=%h dd_oe=%b expected 0 0000 0", da, dd_out, dd_oe); else passes++;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'd0 || rsp_timeout !== 1'b0) $display("FAIL reset_rsp: valid=%b rdata=%h to=%b expected 0 0000 0", rsp_valid, rsp_rdata, rsp_timeout); else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0 || irq_rise !== 1'b0) $display("FAIL reset_irq: irq=%b irq_rise=%b expected 0 0", irq, irq_rise); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready); else passes++;
    intrq = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_read;
    do_txn(1'b0, 1'b0, 3'd7, 16'h0000, 16'h0050, 0, 1'b0);
    checks++; if (o_acc_to !== 1'b0) $display("FAIL read_accept: accept timeout=%b expected 0", o_acc_to); else passes++;
    checks++; if (o_fall !== T_SETUP) $display("FAIL read_fall: dior_ fell at %0d expected %0d", o_fall, T_SETUP); else passes++;
    checks++; if (o_rise - o_fall !== T_PULSE) $display("FAIL read_pulse: width %0d expected %0d", o_rise - o_fall, T_PULSE); else passes++;
    checks++; if (o_rv !== T_SETUP + T_PULSE + T_HOLD) $display("FAIL read_rsp_time: rsp_valid at %0d expected %0d", o_rv, T_SETUP + T_PULSE + T_HOLD); else passes++;
    checks++; if (o_rdata !== 16'h0050 || o_to !== 1'b0) $display("FAIL read_data: rdata=%h to=%b expected 0050 0", o_rdata, o_to); else passes++;
    checks++; if (o_rvcnt !== 1 || o_bad !== 0) $display("FAIL read_bus: rsp pulses=%0d bus errors=%0d expected 1 0", o_rvcnt, o_bad); else passes++;
  endtask

  task automatic test_write;
    do_txn(1'b1, 1'b1, 3'd6, 16'h0004, 16'hDEAD, 0, 1'b0);
    checks++; if (o_fall !== T_SETUP || o_rise - o_fall !== T_PULSE) $display("FAIL write_strobe: fall=%0d width=%0d expected %0d %0d", o_fall, o_rise - o_fall, T_SETUP, T_PULSE); else passes++;
    checks++; if (o_bad !== 0) $display("FAIL write_bus: bus errors=%0d expected 0", o_bad); else passes++;
    checks++; if (o_rv !== T_SETUP + T_PULSE + T_HOLD || o_to !== 1'b0) $display("FAIL write_rsp: rsp at %0d to=%b expected %0d 0", o_rv, o_to, T_SETUP + T_PULSE + T_HOLD); else passes++;
  endtask

  task automatic test_iordy_wait;
    do_txn(1'b0, 1'b0, 3'd1, 16'h0000, 16'hA5C3, 20, 1'b0);
    checks++; if (o_rise !== exp_rise(20)) $display("FAIL wait_rise: dior_ rose at %0d expected %0d", o_rise, exp_rise(20)); else passes++;
    checks++; if (o_rdata !== 16'hA5C3 || o_to !== 1'b0) $display("FAIL wait_data: rdata=%h to=%b expected a5c3 0", o_rdata, o_to); else passes++;
    checks++; if (o_rv !== exp_rise(20) + T_HOLD || o_bad !== 0) $display("FAIL wait_rsp: rsp at %0d errors=%0d expected %0d 0", o_rv, o_bad, exp_rise(20) + T_HOLD); else passes++;
  endtask

  task automatic test_timeout;
    do_txn(1'b0, 1'b1, 3'd2, 16'h0000, 16'h1234, -1, 1'b0);
    checks++; if (o_rise !== T_SETUP + T_PULSE + IORDY_TO) $display("FAIL to_rise: dior_ rose at %0d expected %0d", o_rise, T_SETUP + T_PULSE + IORDY_TO); else passes++;
    checks++; if (o_rdata !== 16'hFFFF || o_to !== 1'b1) $display("FAIL to_data: rdata=%h to=%b expected ffff 1", o_rdata, o_to); else passes++;
    checks++; if (o_ready !== o_rv + T_RECOVER) $display("FAIL to_recover: ready at %0d expected %0d", o_ready, o_rv + T_RECOVER); else passes++;
    do_txn(1'b0, 1'b0, 3'd3, 16'h0000, 16'h7777, 0, 1'b0);
    checks++; if (o_rdata !== 16'h7777 || o_to !== 1'b0) $display("FAIL to_next: rdata=%h to=%b expected 7777 0", o_rdata, o_to); else passes++;
  endtask

  task automatic test_back_to_back;
    int acc1, rv1;
    do_txn(1'b0, 1'b0, 3'd4, 16'h0000, 16'h0BB0, 0, 1'b1);
    acc1 = o_acc_cyc; rv1 = o_rv_cyc;
    checks++; if (o_rvcnt !== 1 || o_bad !== 0) $display("FAIL b2b_first: pulses=%0d errors=%0d expected 1 0", o_rvcnt, o_bad); else passes++;
    do_txn(1'b1, 1'b1, 3'd5, 16'hC0DE, 16'h0000, 0, 1'b0);
    checks++; if (o_acc_cyc - rv1 < T_RECOVER) $display("FAIL b2b_gap: second accept %0d clocks after rsp expected >= %0d", o_acc_cyc - rv1, T_RECOVER); else passes++;
    checks++; if (o_acc_cyc - acc1 !== 1 + T_SETUP + T_PULSE + T_HOLD + T_RECOVER) $display("FAIL b2b_period: %0d expected %0d", o_acc_cyc - acc1, 1 + T_SETUP + T_PULSE + T_HOLD + T_RECOVER); else passes++;
    checks++; if (o_fall !== T_SETUP || o_bad !== 0) $display("FAIL b2b_second: fall=%0d errors=%0d expected %0d 0", o_fall, o_bad, T_SETUP); else passes++;
  endtask

  task automatic test_random;
    logic        w, c3;
    logic [2:0]  a;
    logic [15:0] wd, dev;
    int          low, er;
    for (int i = 0; i < 10; i++) begin
      w   = 1'($urandom_range(0, 1));
      c3  = 1'($urandom_range(0, 1));
      a   = 3'($urandom_range(0, 7));
      wd  = 16'($urandom);
      dev = 16'($urandom);
      low = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      do_txn(w, c3, a, wd, dev, low, 1'b0);
      er = exp_rise(low);
      checks++; if (o_fall !== T_SETUP || o_rise !== er) $display("FAIL rand%0d_strobe: fall=%0d rise=%0d expected %0d %0d", i, o_fall, o_rise, T_SETUP, er); else passes++;
      checks++; if (o_rv !== er + T_HOLD || o_rvcnt !== 1) $display("FAIL rand%0d_rsp: at %0d pulses=%0d expected %0d 1", i, o_rv, o_rvcnt, er + T_HOLD); else passes++;
      checks++; if (o_to !== exp_to(low) || o_bad !== 0) $display("FAIL rand%0d_bus: to=%b errors=%0d expected %b 0", i, o_to, o_bad, exp_to(low)); else passes++;
      checks++; if (o_ready !== er + T_HOLD + T_RECOVER) $display("FAIL rand%0d_ready: at %0d expected %0d", i, o_ready, er + T_HOLD + T_RECOVER); else passes++;
      if (!w) begin
        checks++; if (o_rdata !== dev) $display("FAIL rand%0d_rdata: got %h expected %h", i, o_rdata, dev); else passes++;
      end
    end
  endtask

  task automatic test_rst_mid;
    int wn, rvs;
    req_write = 1'b0; req_cs3 = 1'b0; req_addr = 3'd5; dd_in = 16'h4242; iordy = 1'b1;
    req_valid = 1'b1;
    wn = 0;
    while (req_ready !== 1'b1 && wn < 64) begin @(posedge clk); #1; wn++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (T_SETUP + 2) @(posedge clk);
    #1;
    checks++; if (dior_ !== 1'b0 || cs1fx_ !== 1'b0) $display("FAIL rst_mid_pre: dior_=%b cs1fx_=%b expected 0 0", dior_, cs1fx_); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (dior_ !== 1'b1 || diow_ !== 1'b1 || cs1fx_ !== 1'b1 || cs3fx_ !== 1'b1 || dd_oe !== 1'b0) $display("FAIL rst_mid_async: dior_=%b diow_=%b cs1=%b cs3=%b oe=%b expected 1 1 1 1 0", dior_, diow_, cs1fx_, cs3fx_, dd_oe); else passes++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rvs = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) rvs++;
    end
    checks++; if (rvs !== 0 || req_ready !== 1'b1 || dior_ !== 1'b1) $display("FAIL rst_mid_drop: rsp pulses=%0d ready=%b dior_=%b expected 0 1 1", rvs, req_ready, dior_); else passes++;
  endtask

  task automatic test_irq;
    logic [2:0] seen_irq, seen_rise;
    int rises;
    intrq = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      seen_irq[n] = irq; seen_rise[n] = irq_rise;
    end
    checks++; if (seen_irq !== 3'b110) $display("FAIL irq_level: got %b expected 110", seen_irq); else passes++;
    checks++; if (seen_rise !== 3'b010) $display("FAIL irq_rise_pulse: got %b expected 010", seen_rise); else passes++;
    repeat (3) @(posedge clk);
    #1 intrq = 1'b0;
    rises = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      seen_irq[n] = irq;
      if (irq_rise === 1'b1) rises++;
    end
    checks++; if (seen_irq !== 3'b001 || rises !== 0) $display("FAIL irq_fall: level %b rises %0d expected 001 0", seen_irq, rises); else passes++;
    intrq = 1'b1;
    rises = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (n == 2) intrq = 1'b0;
      if (irq_rise === 1'b1) rises++;
    end
    checks++; if (rises !== 1) $display("FAIL irq_pulse_count: got %0d expected 1", rises); else passes++;
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_iordy_wait;
    test_timeout;
    test_back_to_back;
    test_random;
    test_rst_mid;
    test_irq;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
